// File: rtl/ins_step_sequencer.sv
// ins_step_sequencer: controller step sequencer.
// Generates the step count Cnt and holds the latched instruction word (IR,
// InsM, InsL) that the Signal_* decode blocks use. It fetches at step 0 and
// advances one step per cycle until the decode side returns Buff_PC. It also
// handles HLT/Resume and a sticky step-overrun watchdog.
// Optional feature macro: SEQ_RETIRE_CNT_EN adds the 16-bit Retired counter.
module ins_step_sequencer #(
    parameter int           CNT_W    = 3,
    parameter int           MAX_STEP = 7,
    parameter int           INS_W    = 16,
    parameter logic [4:0]   HLT_OPM  = 5'b11100,
    parameter logic [1:0]   HLT_OPL  = 2'b01
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             Clr,
    input  logic             Mem_rdy,
    input  logic [INS_W-1:0] Mem_ins,
    input  logic             Buff_PC,
    input  logic             Resume,
    output logic             Fetch_req,
    output logic [CNT_W-1:0] Cnt,
    output logic [4:0]       InsM,
    output logic [1:0]       InsL,
    output logic [INS_W-1:0] IR,
    output logic             Halted,
    output logic             Overrun
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]      Retired
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INS_W-1:0]   ir_q, ir_d;
    logic               fetch_req_q, fetch_req_d;
    logic               halted_q, halted_d;
    logic               overrun_q, overrun_d;
    logic               is_hlt;
    logic               retire;

    assign is_hlt = (ir_q[INS_W-1 -: 5] == HLT_OPM) && (ir_q[1:0] == HLT_OPL);

    // Next-state logic: Clr overrides everything. Otherwise the FSM steps
    // through fetch, execution steps and halt.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ir_d        = ir_q;
        fetch_req_d = fetch_req_q;
        halted_d    = halted_q;
        overrun_d   = overrun_q;
        retire      = 1'b0;

        if (Clr) begin
            state_d     = ST_FETCH;
            cnt_d       = '0;
            ir_d        = '0;
            fetch_req_d = 1'b1;
            halted_d    = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    cnt_d = '0;
                    // A word is taken only once the request is visible. This
                    // way the first cycle after reset always shows Fetch_req.
                    if (fetch_req_q && Mem_rdy) begin
                        ir_d        = Mem_ins;
                        cnt_d       = CNT_ONE;
                        fetch_req_d = 1'b0;
                        state_d     = ST_EXEC;
                    end else begin
                        fetch_req_d = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (Buff_PC) begin
                        cnt_d  = '0;
                        retire = 1'b1;
                        if (is_hlt) begin
                            state_d     = ST_HALT;
                            halted_d    = 1'b1;
                            fetch_req_d = 1'b0;
                        end else begin
                            state_d     = ST_FETCH;
                            fetch_req_d = 1'b1;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        overrun_d   = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_FETCH;
                        fetch_req_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HALT: begin
                    cnt_d       = '0;
                    fetch_req_d = 1'b0;
                    halted_d    = 1'b1;
                    if (Resume) begin
                        halted_d    = 1'b0;
                        fetch_req_d = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
                default: begin
                    state_d     = ST_FETCH;
                    cnt_d       = '0;
                    fetch_req_d = 1'b1;
                    halted_d    = 1'b0;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_FETCH;
            cnt_q       <= '0;
            ir_q        <= '0;
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ir_q        <= ir_d;
            fetch_req_q <= fetch_req_d;
            halted_q    <= halted_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;

    // Retired-instruction count: completions only, with natural 16-bit wrap.
    always_comb begin
        retired_d = retired_q;
        if (Clr) begin
            retired_d = '0;
        end else if (retire) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // Retired counter register.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign Retired = retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    assign Fetch_req = fetch_req_q;
    assign Cnt       = cnt_q;
    assign IR        = ir_q;
    assign InsM      = ir_q[INS_W-1 -: 5];
    assign InsL      = ir_q[1:0];
    assign Halted    = halted_q;
    assign Overrun   = overrun_q;

endmodule

// File: doc/ins_step_sequencer.md
Name: ins_step_sequencer

Overview:
- Producer side of the controller timing interface: generates the step count `Cnt` and the latched instruction fields `InsM` and `InsL`.
- These are the signals consumed by the `Signal_*` decode blocks (`Signal_Flag`, `Signal_Buff_PC`, …).
- Fetches an instruction word from memory at step 0 and latches it on the 0→1 step.
- Advances `Cnt` every cycle until the decode block returns `Buff_PC`, then restarts at step 0. Also handles halt and a step-overrun watchdog.

Parameters:
- CNT_W, 3, width of `Cnt`.
- MAX_STEP, 7, last legal step value; reaching it without `Buff_PC` is an overrun.
- INS_W, 16, instruction word width.
- HLT_OPM, 5'b11100, `InsM` code of HLT.
- HLT_OPL, 2'b01, `InsL` code of HLT.

Ports:
- clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Clr  in  1  synchronous active-high soft clear; also drives the decode blocks' `Rst`.
- Mem_rdy  in  1  instruction memory holds a valid word on `Mem_ins` this cycle.
- Mem_ins  in  INS_W  instruction word from memory.
- Buff_PC  in  1  from `Signal_Buff_PC`: current instruction finishes at this step.
- Resume  in  1  single-cycle pulse; leaves HALT.
- Fetch_req  out  1  request instruction fetch; registered.
- Cnt  out  CNT_W  current step; registered.
- InsM  out  5  IR[15:11].
- InsL  out  2  IR[1:0].
- IR  out  INS_W  full latched instruction.
- Halted  out  1  sequencer is in HALT.
- Overrun  out  1  sticky step-overrun error.

Behaviour:
- Reset (`Rst_n`=0, asynchronous): state=FETCH, Cnt=0, IR=0, Fetch_req=0, Halted=0, Overrun=0. The first `Fetch_req`=1 appears on the first clk edge after `Rst_n` deasserts.
- `Clr`=1 at a clk edge: same values as reset, except `Fetch_req` goes to 1 (fetch restarts immediately).
  - `Clr` has priority over every other input.
  - Clearing mid-instruction discards the instruction; `Overrun` is also cleared.
- States: FETCH, EXEC, HALT.
- FETCH (Cnt=0, Fetch_req=1):
  - Mem_rdy=0: hold Cnt=0 and stay in FETCH (stall, no limit).
  - Mem_rdy=1: IR<=Mem_ins, Cnt<=1, Fetch_req<=0, go to EXEC.
  - `InsM`/`InsL` are therefore valid from the first cycle with Cnt=1. This is the capture point the decode blocks rely on.
- EXEC:
  - Evaluate `Buff_PC` every cycle.
  - Buff_PC=1: Cnt<=0, Fetch_req<=1, go to FETCH. This means 0 bubble cycles between instructions.
  - Buff_PC=0 and Cnt<MAX_STEP: Cnt<=Cnt+1.
  - Buff_PC=0 and Cnt==MAX_STEP: Overrun<=1 (sticky), Cnt<=0, go to FETCH. Cnt never wraps silently.
- HLT detection: in EXEC, if IR[15:11]==HLT_OPM, IR[1:0]==HLT_OPL and Buff_PC=1, go to HALT instead of FETCH.
- HALT: Cnt<=0, Fetch_req=0, Halted=1. IR is held, so InsM/InsL stay at the HLT code.
  - Resume=1: Halted<=0, Fetch_req<=1, go to FETCH.
  - Resume outside HALT is ignored.
- Simultaneous events:
  - Clr beats Resume/Buff_PC.
  - Buff_PC at Cnt==MAX_STEP is a normal completion, not an overrun.
  - Mem_rdy outside FETCH is ignored.
- IR changes only on the FETCH→EXEC edge, Clr, or reset.
- `Buff_PC` arrives combinationally from the decode blocks. All outputs of this block are registered, so no combinational loop exists.

Optional Feature:
- Macro `SEQ_RETIRE_CNT_EN`.
- Defined: adds output port `Retired [15:0]`.
  - Reset/Clr value is 0.
  - Increments by 1 on every EXEC exit with Buff_PC=1, including entry to HALT.
  - Excludes overrun exits.
  - Wraps 16'hFFFF→0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then `Mem_rdy`=1, `Mem_ins`=16'h0800 (LHI), Buff_PC asserted at Cnt=2 → Cnt sequence 0,1,2,0; InsM=5'b00001 from the Cnt=1 cycle; Fetch_req=1 at both Cnt=0 cycles.
- Mem_rdy held 0 for 4 cycles in FETCH → Cnt stays 0 and Fetch_req stays 1 for 4 cycles; IR unchanged; latch happens on the cycle Mem_rdy=1.
- Buff_PC never asserted → Cnt 0..7 then 0; Overrun=1 and stays 1 through the next good instruction; Clr pulse → Overrun=0, Cnt=0.
- Mem_ins=16'hE001 (HLT) with Buff_PC at Cnt=2 → Halted=1, Cnt=0, Fetch_req=0 indefinitely; Resume pulse → Halted=0, Fetch_req=1 on the next cycle.
- Rst_n pulled low mid-EXEC at Cnt=3 → Cnt=0, IR=0, Halted=0 immediately without waiting for a clk edge; Clr and Buff_PC asserted in the same cycle → Clr behaviour wins.
- With SEQ_RETIRE_CNT_EN: 3 normal instructions + 1 overrun + HLT → Retired=4.
